// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl
// Capture controller for a small on-chip logic analyser. After an arm pulse it
// fills a circular buffer with pre-trigger history, waits for a masked trigger
// match, records post-trigger samples, then freezes the buffer for readout.
// Readout index 0 is always the oldest sample of the frozen window.
// Optional feature: define ILA_CAPTURE_EDGE_EN to add the trig_edge input,
// which restricts the trigger to a false-to-true transition of the match.
module ila_capture_ctrl #(
   parameter int PROBE_W = 32,
   parameter int ADDR_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PROBE_W-1:0] probe,
   input  logic               arm,
   input  logic               abort,
   input  logic [PROBE_W-1:0] trig_mask,
   input  logic [PROBE_W-1:0] trig_value,
   input  logic [ADDR_W-1:0]  post_cnt,
`ifdef ILA_CAPTURE_EDGE_EN
   input  logic               trig_edge,
`endif
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [PROBE_W-1:0] rd_data,
   output logic               rd_valid,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  trig_pos
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_WAIT_TRIG,
      S_POST,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [PROBE_W-1:0] mask_q, mask_d;
   logic [PROBE_W-1:0] value_q, value_d;
   logic [ADDR_W-1:0]  post_q, post_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0]  trig_addr_q, trig_addr_d;
   logic [ADDR_W-1:0]  trig_pos_q, trig_pos_d;
   logic               rd_valid_q, rd_valid_d;
   logic [PROBE_W-1:0] rd_data_q;

   logic [PROBE_W-1:0] mem [DEPTH];
   logic               mem_we;
   logic               mem_re;
   logic [ADDR_W-1:0]  mem_raddr;

   logic               match;
   logic               trig_fire;
   logic [ADDR_W-1:0]  pre_last;

`ifdef ILA_CAPTURE_EDGE_EN
   logic               edge_q, edge_d;
   logic               prev_match_q, prev_match_d;
`endif

   // Masked trigger compare and, when enabled, rising-edge qualification.
   always_comb begin
      match    = ((probe ^ value_q) & mask_q) == '0;
      pre_last = ~post_q - ADDR_W'(1);
`ifdef ILA_CAPTURE_EDGE_EN
      trig_fire = match && (!edge_q || !prev_match_q);
`else
      trig_fire = match;
`endif
   end

   // Next-state logic: arming, buffer writes, phase counters and abort override.
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      value_d     = value_q;
      post_d      = post_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q;
      trig_addr_d = trig_addr_q;
      trig_pos_d  = trig_pos_q;
      mem_we      = 1'b0;
`ifdef ILA_CAPTURE_EDGE_EN
      edge_d       = edge_q;
      prev_match_d = prev_match_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm) begin
               mask_d     = trig_mask;
               value_d    = trig_value;
               post_d     = post_cnt;
               wr_ptr_d   = '0;
               cnt_d      = '0;
               trig_pos_d = ~post_cnt;
`ifdef ILA_CAPTURE_EDGE_EN
               edge_d       = trig_edge;
               prev_match_d = 1'b0;
`endif
               // A full-depth post window leaves no room for history at all.
               state_d = (&post_cnt) ? S_WAIT_TRIG : S_PRE;
            end
         end

         S_PRE: begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            cnt_d    = cnt_q + ADDR_W'(1);
`ifdef ILA_CAPTURE_EDGE_EN
            prev_match_d = match;
`endif
            if (cnt_q == pre_last) begin
               cnt_d   = '0;
               state_d = S_WAIT_TRIG;
            end
         end

         S_WAIT_TRIG: begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
`ifdef ILA_CAPTURE_EDGE_EN
            prev_match_d = match;
`endif
            if (trig_fire) begin
               trig_addr_d = wr_ptr_q;
               cnt_d       = '0;
               state_d     = (post_q == '0) ? S_DONE : S_POST;
            end
         end

         S_POST: begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            cnt_d    = cnt_q + ADDR_W'(1);
            if (cnt_q == post_q - ADDR_W'(1)) begin
               state_d = S_DONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over any same-cycle arm, trigger or write.
      if (abort) begin
         state_d = S_IDLE;
         mem_we  = 1'b0;
      end
   end

   // Readout request decode: oldest sample sits trig_pos entries before the trigger.
   always_comb begin
      mem_re     = rd_en && (state_q == S_DONE);
      mem_raddr  = trig_addr_q - trig_pos_q + rd_addr;
      rd_valid_d = mem_re;
   end

   // Control and configuration registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         value_q     <= '0;
         post_q      <= '0;
         wr_ptr_q    <= '0;
         cnt_q       <= '0;
         trig_addr_q <= '0;
         trig_pos_q  <= '0;
         rd_valid_q  <= 1'b0;
`ifdef ILA_CAPTURE_EDGE_EN
         edge_q       <= 1'b0;
         prev_match_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         value_q     <= value_d;
         post_q      <= post_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         trig_addr_q <= trig_addr_d;
         trig_pos_q  <= trig_pos_d;
         rd_valid_q  <= rd_valid_d;
`ifdef ILA_CAPTURE_EDGE_EN
         edge_q       <= edge_d;
         prev_match_q <= prev_match_d;
`endif
      end
   end

   // Buffer write port; contents are left unreset so the array maps onto RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr_q] <= probe;
      end
   end

   // Buffer read port, registered directly off the array so it stays a synchronous RAM read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (mem_re) begin
         rd_data_q <= mem[mem_raddr];
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign busy     = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
   assign done     = (state_q == S_DONE);
   assign trig_pos = trig_pos_q;

endmodule

// File: doc/ila_capture_ctrl.md
ILA_CAPTURE_CTRL -- requirements
Module: ila_capture_ctrl

Interface
REQ-001 Parameter PROBE_W, default 32: width of the captured probe word.
REQ-002 Parameter ADDR_W, default 4: buffer address width; DEPTH = 2**ADDR_W samples.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 probe  input  PROBE_W  sample written to the buffer each capturing cycle.
REQ-006 arm  input  1  single-cycle start-capture pulse.
REQ-007 abort  input  1  single-cycle cancel pulse.
REQ-008 trig_mask  input  PROBE_W  bits taking part in the trigger compare.
REQ-009 trig_value  input  PROBE_W  trigger compare value.
REQ-010 post_cnt  input  ADDR_W  samples captured after the trigger sample.
REQ-011 rd_en  input  1  readout request.
REQ-012 rd_addr  input  ADDR_W  readout index; 0 = oldest sample.
REQ-013 rd_data  output  PROBE_W  readout sample.
REQ-014 rd_valid  output  1  rd_data is valid this cycle.
REQ-015 busy  output  1  high in PRE, WAIT_TRIG and POST.
REQ-016 done  output  1  high in DONE.
REQ-017 trig_pos  output  ADDR_W  readout index of the trigger sample, DEPTH-1-post_cnt (latched).

Function
REQ-018 States IDLE, PRE, WAIT_TRIG, POST, DONE, one-hot or binary; no other reachable state.
REQ-019 arm in IDLE or DONE: latch trig_mask, trig_value and post_cnt; clear the write pointer and counters; enter PRE. arm in any other state is ignored.
REQ-020 PRE, WAIT_TRIG, POST: write probe to buffer[wr_ptr] and increment wr_ptr modulo DEPTH every cycle.
REQ-021 PRE: leave for WAIT_TRIG after DEPTH-1-post_cnt samples; with post_cnt = DEPTH-1, skip directly to WAIT_TRIG on the first cycle. A trigger match in PRE is ignored.
REQ-022 Match: (probe & mask) == (value & mask); an all-zero mask matches on the first WAIT_TRIG cycle.
REQ-023 WAIT_TRIG match: the matching sample is written and its address recorded; go to POST, or to DONE when post_cnt = 0.
REQ-024 POST: after exactly post_cnt further samples, enter DONE; capture stops, and the buffer is frozen.
REQ-025 DONE: physical read address = (trigger address - (DEPTH-1-post_cnt) + rd_addr) mod DEPTH.
REQ-026 rd_en in DONE: rd_data and rd_valid=1 one cycle later; rd_en outside DONE gives rd_valid=0. rd_data holds its last value when rd_valid is low.
REQ-027 abort in any state: IDLE next cycle; abort takes priority over a same-cycle arm or trigger.
REQ-028 Buffer storage is inferred RAM with one synchronous write port and one synchronous read port; no reset on the contents.

Reset
REQ-029 rst: state=IDLE; wr_ptr, counters, trig_pos and rd_data=0; rd_valid, busy and done=0; mid-capture reset discards the capture.

Configuration
REQ-030 Macro ILA_CAPTURE_EDGE_EN defined: add input trig_edge (1 bit, latched on arm); when it is 1, the trigger fires only when the match is true this cycle and was false on the previous capturing cycle. The first WAIT_TRIG cycle counts as previous-false only when the last PRE sample did not match.
REQ-031 Macro absent: trig_edge port does not exist; trigger is level match only.

Verification (ADDR_W=4, DEPTH=16, PROBE_W=8; probe = 0,1,2,... from the first cycle after arm)
REQ-032 mask=FF, value=20, post_cnt=4 -> trig_pos=11, done 5 cycles after the sample-0x20 write; rd_addr 0..15 returns 15..24 hex, one cycle latency.
REQ-033 mask=00, post_cnt=0 -> 15 PRE samples, trigger on sample 0F, done next cycle; readout 00..0F; trig_pos=15.
REQ-034 mask=FF, value=03, post_cnt=4 with probe wrapping at 0x40 -> match on sample 03 (in PRE) is ignored; trigger on sample 43-wrapped 03 is taken; readout has 03 at index 11.
REQ-035 abort during POST -> busy=0 and done=0 next cycle; rd_en then gives rd_valid=0; a new arm with the same settings completes normally.
REQ-036 rst held 1 cycle during WAIT_TRIG -> all outputs at reset values; arm+mask=00 afterwards reaches DONE in 16 cycles for post_cnt=0.
REQ-037 With ILA_CAPTURE_EDGE_EN, trig_edge=1, mask=01, value=01, probe bit0 high for whole PRE -> no trigger until bit0 falls and rises again; trigger on the rising sample.
